// File: rtl/trafgen_ctrl_pkg.sv
// Shared definitions for the traffic-generator controller: FSM states,
// register offsets of the generator's AXI-Lite block and error bit positions.
package trafgen_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_LEN,
    WR_EN,
    STREAM,
    WR_DIS,
    NEXT,
    DONE
  } state_e;

  localparam int unsigned REG_ENABLE = 0;
  localparam int unsigned REG_LENGTH = 4;

  localparam int unsigned ERR_BRESP = 0;
  localparam int unsigned ERR_FRAME = 1;

endpackage

// File: rtl/trafgen_ctrl_if.sv
// AXI-Lite write channel bundle between the controller (master) and the
// generator's register block (slave).
interface trafgen_ctrl_if
  import trafgen_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/trafgen_axil_wr.sv
// Single-outstanding AXI-Lite write engine: a req pulse launches AW and W
// together from the next cycle; ack pulses on the B handshake.
module trafgen_axil_wr
  import trafgen_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ack_o,
  output logic [1:0]            bresp_o,
  trafgen_ctrl_if.master        axi
);

  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  bready_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  // Each channel retires independently; bready spans the whole transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
    end else if (req_i) begin
      awvalid_q <= 1'b1;
      wvalid_q  <= 1'b1;
      bready_q  <= 1'b1;
      awaddr_q  <= addr_i;
      wdata_q   <= data_i;
    end else begin
      if (axi.awready) awvalid_q <= 1'b0;
      if (axi.wready)  wvalid_q  <= 1'b0;
      if (axi.bvalid)  bready_q  <= 1'b0;
    end
  end

  assign axi.awaddr  = awaddr_q;
  assign axi.awprot  = 3'b000;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = '1;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;

  assign ack_o   = bready_q && axi.bvalid;
  assign bresp_o = axi.bresp;

endmodule

// File: rtl/trafgen_ctrl.sv
// Run controller for the NTT/INTT traffic generator: programs length and
// enable over AXI-Lite, watches the stream for framing, repeats per pass.
module trafgen_ctrl
  import trafgen_ctrl_pkg::*;
#(
  parameter int C_M00_AXI_ADDR_WIDTH = 4,
  parameter int C_M00_AXI_DATA_WIDTH = 32,
  parameter int C_LEN_WIDTH          = 16
) (
  input  logic                   m00_axi_aclk,
  input  logic                   m00_axi_aresetn,
  input  logic                   start,
  input  logic [C_LEN_WIDTH-1:0] num_words,
  input  logic [7:0]             num_passes,
  input  logic                   first_sel,
  input  logic                   abort,
  trafgen_ctrl_if.master         m00_axi,
  input  logic                   mon_tvalid,
  input  logic                   mon_tready,
  input  logic                   mon_tlast,
  output logic                   NTT_INTT_sel,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             pass_count,
  output logic [1:0]             error
);

  state_e                   state_q, state_d;
  logic [C_LEN_WIDTH-1:0]   len_q, len_d;
  logic [7:0]               passes_q, passes_d;
  logic [C_LEN_WIDTH-1:0]   beat_q, beat_d;
  logic [7:0]               pass_count_q, pass_count_d;
  logic                     sel_q, sel_d;
  logic [1:0]               error_q, error_d;
  logic                     abort_q, abort_d;

  logic                            wr_req;
  logic [C_M00_AXI_ADDR_WIDTH-1:0] wr_addr;
  logic [C_M00_AXI_DATA_WIDTH-1:0] wr_data;
  logic                            wr_ack;
  logic [1:0]                      wr_bresp;
  logic                            beat;
  logic                            aborting;

  assign beat     = mon_tvalid && mon_tready;
  assign aborting = abort || abort_q;

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      state_q      <= IDLE;
      len_q        <= '0;
      passes_q     <= '0;
      beat_q       <= '0;
      pass_count_q <= '0;
      sel_q        <= 1'b0;
      error_q      <= '0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      passes_q     <= passes_d;
      beat_q       <= beat_d;
      pass_count_q <= pass_count_d;
      sel_q        <= sel_d;
      error_q      <= error_d;
      abort_q      <= abort_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    passes_d     = passes_q;
    beat_d       = beat_q;
    pass_count_d = pass_count_q;
    sel_d        = sel_q;
    error_d      = error_q;
    abort_d      = abort_q;

    // abort_q remembers a short abort pulse until the in-flight write retires
    if (state_q != IDLE && state_q != DONE && abort) abort_d = 1'b1;
    if (wr_ack && wr_bresp != 2'b00) error_d[ERR_BRESP] = 1'b1;

    case (state_q)
      IDLE: begin
        if (start && num_words != '0 && num_passes != '0) begin
          len_d        = num_words;
          passes_d     = num_passes;
          pass_count_d = '0;
          error_d      = '0;
          sel_d        = first_sel;
          abort_d      = 1'b0;
          state_d      = WR_LEN;
        end
      end
      WR_LEN: if (wr_ack) state_d = aborting ? WR_DIS : WR_EN;
      WR_EN: begin
        beat_d = '0;
        if (wr_ack) state_d = aborting ? WR_DIS : STREAM;
      end
      STREAM: begin
        if (beat) begin
          if (beat_q == len_q - 1'b1) begin
            if (!mon_tlast) error_d[ERR_FRAME] = 1'b1;
            state_d = WR_DIS;
          end else begin
            if (mon_tlast) error_d[ERR_FRAME] = 1'b1;
            beat_d = beat_q + 1'b1;
          end
        end
        if (abort) state_d = WR_DIS;
      end
      WR_DIS: if (wr_ack) state_d = aborting ? IDLE : NEXT;
      NEXT: begin
        if (abort) begin
          state_d = WR_DIS;
        end else begin
          pass_count_d = pass_count_q + 8'd1;
          if (pass_count_q + 8'd1 == passes_q) begin
            state_d = DONE;
          end else begin
            sel_d   = ~sel_q;
            state_d = WR_EN;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Launch a write on entry to a write state so valids are up in its first cycle.
  always_comb begin
    wr_req  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (state_d != state_q) begin
      case (state_d)
        WR_LEN: begin
          wr_req  = 1'b1;
          wr_addr = C_M00_AXI_ADDR_WIDTH'(REG_LENGTH);
          wr_data = C_M00_AXI_DATA_WIDTH'(len_d);
        end
        WR_EN: begin
          wr_req  = 1'b1;
          wr_addr = C_M00_AXI_ADDR_WIDTH'(REG_ENABLE);
          wr_data = C_M00_AXI_DATA_WIDTH'(1);
        end
        WR_DIS: begin
          wr_req  = 1'b1;
          wr_addr = C_M00_AXI_ADDR_WIDTH'(REG_ENABLE);
          wr_data = '0;
        end
        default: wr_req = 1'b0;
      endcase
    end
  end

  trafgen_axil_wr #(
    .ADDR_WIDTH(C_M00_AXI_ADDR_WIDTH),
    .DATA_WIDTH(C_M00_AXI_DATA_WIDTH)
  ) u_axil_wr (
    .clk     (m00_axi_aclk),
    .rst_n   (m00_axi_aresetn),
    .req_i   (wr_req),
    .addr_i  (wr_addr),
    .data_i  (wr_data),
    .ack_o   (wr_ack),
    .bresp_o (wr_bresp),
    .axi     (m00_axi)
  );

  assign NTT_INTT_sel = sel_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign pass_count   = pass_count_q;
  assign error        = error_q;

endmodule

// File: tb/tb_trafgen_ctrl.sv
// Directed bench for trafgen_ctrl: an AXI-Lite slave/scoreboard process plus
// run-level expectations built from the configured words/passes/faults.
module tb_trafgen_ctrl;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] num_words = '0;
  logic [7:0]    num_passes = '0;
  logic          first_sel = 1'b0;
  logic          abort = 1'b0;
  logic          mon_tvalid = 1'b0;
  logic          mon_tready = 1'b0;
  logic          mon_tlast = 1'b0;
  logic          sel, busy, done;
  logic [7:0]    pass_count;
  logic [1:0]    error;

  trafgen_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  trafgen_ctrl #(
    .C_M00_AXI_ADDR_WIDTH(AW),
    .C_M00_AXI_DATA_WIDTH(DW),
    .C_LEN_WIDTH(LW)
  ) dut (
    .m00_axi_aclk    (clk),
    .m00_axi_aresetn (rst_n),
    .start           (start),
    .num_words       (num_words),
    .num_passes      (num_passes),
    .first_sel       (first_sel),
    .abort           (abort),
    .m00_axi         (axi),
    .mon_tvalid      (mon_tvalid),
    .mon_tready      (mon_tready),
    .mon_tlast       (mon_tlast),
    .NTT_INTT_sel    (sel),
    .busy            (busy),
    .done            (done),
    .pass_count      (pass_count),
    .error           (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t log_q[$];
  int  n_tests = 0;
  int  n_fail = 0;
  int  aw_delay = 0;
  int  w_delay = 0;
  int  en_cnt = 0;
  int  done_cnt = 0;
  bit  bresp_err_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic fail_now(input string nm, input string why);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s at %0t", nm, why, $time);
  endtask

  // AXI-Lite slave with programmable ready delays, plus per-cycle bus checks
  // and the write scoreboard. Acts at negedge on what the last cycle did.
  initial begin : slave
    int            aw_cnt, w_cnt;
    bit            aw_hs, w_hs, in_txn;
    logic          p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_done;
    logic [AW-1:0] p_addr, cap_addr;
    logic [DW-1:0] p_data, cap_data;
    wr_t           got, want;
    aw_cnt = 0; w_cnt = 0; aw_hs = 0; w_hs = 0; in_txn = 0;
    p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_bv = 0; p_br = 0; p_done = 0;
    p_addr = '0; p_data = '0; cap_addr = '0; cap_data = '0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
        aw_cnt = 0; w_cnt = 0; aw_hs = 0; w_hs = 0; in_txn = 0;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_bv = 0; p_br = 0; p_done = 0;
      end else begin
        if (p_bv && p_br) begin
          got.a = cap_addr;
          got.d = cap_data;
          log_q.push_back(got);
          $display("[TB] write addr=0x%0h data=0x%0h", got.a, got.d);
          if (cap_addr == 0 && cap_data == 1) en_cnt++;
          if (exp_q.size() == 0) begin
            fail_now("unexpected_write", $sformatf("addr=0x%0h data=0x%0h, none expected", got.a, got.d));
          end else begin
            want = exp_q.pop_front();
            chk("wr_addr", got.a, want.a);
            chk("wr_data", got.d, want.d);
          end
          axi.bvalid = 1'b0;
          in_txn = 0; aw_hs = 0; w_hs = 0; aw_cnt = 0; w_cnt = 0;
        end
        if (p_awv && p_awr) begin
          chk("aw_hold_cycles", aw_cnt, aw_delay + 1);
          aw_hs = 1; cap_addr = p_addr;
        end
        if (p_wv && p_wr) begin
          chk("w_hold_cycles", w_cnt, w_delay + 1);
          w_hs = 1; cap_data = p_data;
        end
        if (axi.awvalid && !in_txn) begin
          in_txn = 1;
          chk("w_rises_with_aw", axi.wvalid, 1'b1);
        end
        if (in_txn) begin
          chk("bready_hold", axi.bready, 1'b1);
          if (aw_hs) chk("aw_drop", axi.awvalid, 1'b0);
          if (w_hs) chk("w_drop", axi.wvalid, 1'b0);
        end
        if (axi.awvalid) begin
          chk("awprot", axi.awprot, 3'b000);
          if (p_awv && !p_awr) chk("awaddr_stable", axi.awaddr, p_addr);
        end
        if (axi.wvalid) begin
          chk("wstrb", axi.wstrb, 4'hf);
          if (p_wv && !p_wr) chk("wdata_stable", axi.wdata, p_data);
        end
        if (axi.awvalid || axi.wvalid || axi.bready || done)
          chk("busy_when_active", busy, 1'b1);
        if (done) begin
          done_cnt++;
          chk("done_single_cycle", p_done, 1'b0);
        end
        if (axi.awvalid && !aw_hs) begin
          aw_cnt++;
          axi.awready = (aw_cnt > aw_delay);
        end else begin
          axi.awready = 1'b0;
        end
        if (axi.wvalid && !w_hs) begin
          w_cnt++;
          axi.wready = (w_cnt > w_delay);
        end else begin
          axi.wready = 1'b0;
        end
        if (in_txn && aw_hs && w_hs && !axi.bvalid && !(p_bv && p_br)) begin
          axi.bvalid = 1'b1;
          axi.bresp = (bresp_err_en && cap_addr == 0 && cap_data == 1) ? 2'b10 : 2'b00;
        end
        p_awv = axi.awvalid; p_awr = axi.awready;
        p_wv  = axi.wvalid;  p_wr  = axi.wready;
        p_bv  = axi.bvalid;  p_br  = axi.bready;
        p_addr = axi.awaddr; p_data = axi.wdata; p_done = done;
      end
    end
  end

  // One run: expected write list and final status come from the config alone.
  task automatic run_case(input string nm, input int nw, input int np, input bit fsel,
                          input int wdel, input int tl_at, input bit berr, input int abort_at);
    int       waited;
    bit       stop;
    bit       ab;
    wr_t      e;
    stop = 0;
    ab = (abort_at != 0);
    exp_q.delete();
    log_q.delete();
    done_cnt = 0; en_cnt = 0; w_delay = wdel; bresp_err_en = berr;
    e.a = 4; e.d = DW'(nw);
    exp_q.push_back(e);
    for (int p = 0; p < np; p++) begin
      e.a = 0; e.d = 1; exp_q.push_back(e);
      e.a = 0; e.d = 0; exp_q.push_back(e);
      if (ab) break;
    end
    @(negedge clk); #2;
    num_words = LW'(nw); num_passes = 8'(np); first_sel = fsel; start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0; num_words = 16'hBEEF; num_passes = 8'd200; first_sel = ~fsel;
    for (int p = 0; p < np && !stop; p++) begin
      waited = 0;
      while (en_cnt < p + 1 && waited < 100) begin
        @(negedge clk); #2;
        waited++;
      end
      if (en_cnt < p + 1) begin
        fail_now({nm, "_enable_wait"}, "no ENABLE write within 100 cycles");
        stop = 1;
      end else begin
        for (int b = 1; b <= nw; b++) begin
          chk({nm, "_sel"}, sel, fsel ^ 1'(p % 2));
          mon_tvalid = 1'b1; mon_tready = 1'b1;
          mon_tlast = (b == tl_at); abort = (b == abort_at); start = (b == 2);
          @(negedge clk); #2;
          if (b == abort_at) begin
            stop = 1;
            break;
          end
        end
        mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0; abort = 1'b0; start = 1'b0;
      end
    end
    waited = 0;
    while (busy && waited < 300) begin
      @(negedge clk); #2;
      waited++;
    end
    if (busy) fail_now({nm, "_idle_wait"}, "still busy after 300 cycles");
    chk({nm, "_writes_left"}, exp_q.size(), 0);
    chk({nm, "_done_pulses"}, done_cnt, ab ? 0 : 1);
    chk({nm, "_error"}, error, {(tl_at != nw) && !ab, berr});
    if (!ab) chk({nm, "_pass_count"}, pass_count, np);
    $display("[TB] case %s: words=%0d passes=%0d writes=%0d done=%0d error=%b", nm, nw, np,
             log_q.size(), done_cnt, error);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int  waited;
    bit  act;
    wr_t e;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 2'b00);
    chk("rst_pass_count", pass_count, 8'd0);
    chk("rst_sel", sel, 1'b0);
    chk("rst_awvalid", axi.awvalid, 1'b0);
    chk("rst_wvalid", axi.wvalid, 1'b0);
    chk("rst_bready", axi.bready, 1'b0);
    chk("rst_awaddr", axi.awaddr, 4'h0);
    chk("rst_wdata", axi.wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_case("c1_basic", 256, 1, 1'b1, 0, 256, 1'b0, 0);
    chk("c1_nwrites", log_q.size(), 3);
    chk("c1_w0_addr", log_q[0].a, 4'h4);
    chk("c1_w0_data", log_q[0].d, 32'd256);
    chk("c1_w1_data", log_q[1].d, 32'd1);
    chk("c1_w2_data", log_q[2].d, 32'd0);

    run_case("c2_passes", 4, 3, 1'b0, 0, 4, 1'b0, 0);
    chk("c2_nwrites", log_q.size(), 7);
    chk("c2_pass_count", pass_count, 8'd3);

    run_case("c3_wdelay", 4, 1, 1'b0, 5, 4, 1'b0, 0);
    chk("c3_nwrites", log_q.size(), 3);

    run_case("c4_framing", 8, 1, 1'b0, 0, 5, 1'b0, 0);
    chk("c4_error", error, 2'b10);

    run_case("c5_bresp", 4, 1, 1'b1, 0, 4, 1'b1, 0);
    chk("c5_error", error, 2'b01);

    run_case("c6_abort", 256, 1, 1'b0, 0, 256, 1'b0, 100);
    chk("c6_nwrites", log_q.size(), 3);
    chk("c6_last_addr", log_q[2].a, 4'h0);
    chk("c6_last_data", log_q[2].d, 32'd0);

    run_case("c7_restart", 4, 2, 1'b1, 0, 4, 1'b0, 0);

    // Reset while the ENABLE write is waiting on awready
    exp_q.delete(); log_q.delete();
    aw_delay = 3; w_delay = 0; bresp_err_en = 1'b0;
    e.a = 4; e.d = 4; exp_q.push_back(e);
    @(negedge clk); #2;
    num_words = 16'd4; num_passes = 8'd1; first_sel = 1'b1; start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
    waited = 0;
    while (!(axi.awvalid && axi.awaddr == 0) && waited < 100) begin
      @(negedge clk); #2;
      waited++;
    end
    if (!(axi.awvalid && axi.awaddr == 0)) fail_now("rst_mid_wait", "ENABLE write never started");
    rst_n = 1'b0;
    #1;
    chk("rst_mid_awvalid", axi.awvalid, 1'b0);
    chk("rst_mid_wvalid", axi.wvalid, 1'b0);
    chk("rst_mid_bready", axi.bready, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_sel", sel, 1'b0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    aw_delay = 0;
    repeat (20) @(negedge clk);
    chk("rst_mid_nwrites", log_q.size(), 1);
    chk("rst_mid_writes_left", exp_q.size(), 0);
    $display("[TB] case rst_mid: writes=%0d busy=%0b", log_q.size(), busy);

    // Zero words or zero passes: start must be ignored
    log_q.delete();
    @(negedge clk); #2;
    num_words = 16'd0; num_passes = 8'd1; start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
    act = 0;
    repeat (20) begin
      @(negedge clk); #2;
      if (busy || axi.awvalid || axi.wvalid || axi.bready) act = 1;
    end
    chk("zero_words_idle", act, 1'b0);
    num_words = 16'd4; num_passes = 8'd0; start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
    act = 0;
    repeat (20) begin
      @(negedge clk); #2;
      if (busy || axi.awvalid || axi.wvalid || axi.bready) act = 1;
    end
    chk("zero_passes_idle", act, 1'b0);
    chk("zero_nwrites", log_q.size(), 0);
    $display("[TB] case zero_cfg: writes=%0d", log_q.size());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
